// File: rtl/perceptron_trainer.sv
// Perceptron training stage: applies the perceptron learning rule to the
// weight and bias registers it owns, one weight per cycle, under a
// valid/ready handshake, and keeps a saturating misclassification counter.
module perceptron_trainer #(
  parameter int N_IN   = 7,
  parameter int W      = 8,
  parameter int LR     = 4,
  parameter int W_INIT = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic [N_IN-1:0]        features,
  input  logic                   label,
  input  logic                   prediction,
  input  logic                   freeze,
  input  logic                   clear_err,
  output logic [N_IN*W-1:0]      weights,
  output logic signed [W-1:0]    bias,
  output logic                   upd_busy,
  output logic                   upd_done,
  output logic [CNT_W-1:0]       err_count
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, BIAS, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_IN-1:0]        feat_q;
  logic                   label_q;
  logic signed [W-1:0]    w_q [N_IN];
  logic signed [W-1:0]    bias_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   accept;
  logic                   err;

  // Step a Q2.6 value by +/-LR in W+1 bits, clamping to the signed W-bit range.
  function automatic logic signed [W-1:0] sat_step(input logic signed [W-1:0] a,
                                                   input logic up);
    logic signed [W:0] ext;
    logic signed [W:0] step;
    logic signed [W:0] sum;
    ext  = {a[W-1], a};
    step = (W+1)'(LR);
    sum  = up ? (ext + step) : (ext - step);
    if (sum[W] != sum[W-1])
      sat_step = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat_step = sum[W-1:0];
  endfunction

  // Misclassification is judged on the live inputs at the accept edge.
  assign err = (label != prediction);

  // Next-state and handshake/status decode; prediction and freeze are fully
  // consumed at acceptance, so only features and label need latching.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sample_ready = 1'b0;
    upd_busy     = 1'b0;
    upd_done     = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = (err && !freeze) ? UPDATE : DONE;
        end
      end
      UPDATE: begin
        upd_busy = 1'b1;
        if (idx_q == IDX_LAST) state_d = BIAS;
        else                   idx_d   = idx_q + 1'b1;
      end
      BIAS: begin
        upd_busy = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        upd_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Latched sample, weight/bias learning updates and the saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) w_q[i] <= W'(W_INIT);
      bias_q  <= W'(W_INIT);
      cnt_q   <= '0;
      feat_q  <= '0;
      label_q <= 1'b0;
    end else begin
      if (accept) begin
        feat_q  <= features;
        label_q <= label;
      end
      // An update only runs after an error, so label alone gives the direction.
      for (int i = 0; i < N_IN; i++) begin
        if (state_q == UPDATE && idx_q == IDX_W'(i) && feat_q[i])
          w_q[i] <= sat_step(w_q[i], label_q);
      end
      if (state_q == BIAS)
        bias_q <= sat_step(bias_q, label_q);
      if (clear_err)
        cnt_q <= '0;
      else if (accept && err && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Pack the weight array for the classifier.
  for (genvar g = 0; g < N_IN; g++) begin : g_pack
    assign weights[g*W +: W] = w_q[g];
  end

  assign bias      = bias_q;
  assign err_count = cnt_q;

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Downstream stage of the 7-input perceptron classifier.
- Consumes each classified sample: feature bits, the perceptron's prediction, and the true label.
- Applies the perceptron learning rule to the weight and bias registers it owns, and drives them back to the classifier.
- Runs one weight update per cycle under a valid/ready handshake, and keeps a saturating misclassification counter.

Parameters:
N_IN, 7, number of feature inputs/weights
W, 8, weight/bias width; signed two's complement, Q2.6 (LSB = 1/64)
LR, 4, learning-rate step added/subtracted per update (4 = 0.0625)
W_INIT, 32, reset value of every weight and of bias (32 = 0.5)
CNT_W, 16, error-counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
sample_valid  input  1  sample presented
sample_ready  output  1  trainer can accept a sample
features  input  N_IN  feature bits x[i] of the sample
label  input  1  true class (0/1)
prediction  input  1  class produced by the perceptron for this sample
freeze  input  1  1 = inference only: count errors, no weight/bias change
clear_err  input  1  synchronous clear of err_count
weights  output  N_IN*W  packed weights, w[i] at bits [i*W +: W]
bias  output  W  bias register
upd_busy  output  1  high while weights/bias may change
upd_done  output  1  one-cycle pulse: sample fully processed
err_count  output  CNT_W  misclassifications since reset/clear, saturating

Behaviour:
- Reset (rst_n=0 at posedge), regardless of state:
  - all weights and bias = W_INIT; err_count = 0; state = IDLE
  - sample_ready = 1, upd_busy = 0, upd_done = 0
  - reset mid-update abandons the update.
- States: IDLE, UPDATE, BIAS, DONE.
- IDLE:
  - sample_ready = 1.
  - On sample_valid & sample_ready: latch features, label, prediction, freeze; set err = (label != prediction).
  - If err: err_count += 1, saturating at all-ones.
  - If err & !freeze: go to UPDATE with idx = 0. Else go to DONE.
- UPDATE:
  - One weight per cycle, idx 0..N_IN-1.
  - If latched x[idx] = 1: w[idx] += LR when label=1/prediction=0, w[idx] -= LR when label=0/prediction=1. If x[idx] = 0: w[idx] unchanged.
  - After idx = N_IN-1, go to BIAS.
- BIAS: bias += or -= LR, same sign rule; go to DONE.
- DONE: upd_done = 1 for exactly this cycle; go to IDLE.
- sample_ready = 0 in UPDATE, BIAS, DONE. upd_busy = 1 in UPDATE and BIAS.
- Latency from acceptance at edge N:
  - no update: upd_done high in cycle N+1
  - update: weights change at edges N+1..N+7, bias at N+8, upd_done in cycle N+9
  - next sample accepted no earlier than the edge ending the upd_done cycle + 1, i.e. back-to-back throughput is 2 cycles (no update) or 10 cycles (update).
- Arithmetic:
  - Sign-extend to W+1 bits before add/subtract.
  - Saturate to [-2^(W-1), 2^(W-1)-1]: 127 + 4 -> 127; -128 - 4 -> -128.
  - No wrap-around ever.
- Inputs other than the handshake are sampled only at the accept edge; changes afterwards are ignored.
- sample_valid while not ready: ignored, nothing latched. The upstream must hold it.
- clear_err: err_count = 0 next edge. If the same edge would increment, clear wins and the result is 0.
- The classifier must not use weights/bias while upd_busy = 1.

Test Plan:
1. Reset, then check outputs → every w[i] = 32, bias = 32, err_count = 0, sample_ready = 1, upd_done = 0.
2. Correct sample: features=7'h55, label=1, prediction=1 → upd_done in the cycle after accept; weights/bias unchanged; err_count = 0.
3. False negative: features=7'b0000101, label=1, prediction=0 → w[0] = 36, w[2] = 36, others 32, bias = 36; upd_done 9 cycles after accept; err_count = 1; sample_ready low for cycles N+1..N+9.
4. Saturation: 30 false negatives with features=7'h7F → all weights and bias step by 4 to 127 and stay at 127. Then false positives from -128 → stays at -128. err_count increments to 30 then continues.
5. freeze=1, label=0, prediction=1 → err_count increments, weights unchanged, upd_done one cycle after accept. Also clear_err asserted on the same edge as an erroring accept → err_count = 0.
6. rst_n low at edge N+4 of an update → all weights 32, bias 32, state IDLE, sample_ready = 1 next cycle, no upd_done pulse. sample_valid held during busy is not double-accepted.
